// File: rtl/mult_share_arb_if.sv
// mult_share_arb_if: requester, shared-multiplier and result-stream signals of the arbiter
interface mult_share_arb_if #(
    parameter int WIDTH = 24,
    parameter int NREQ  = 4,
    parameter int IDW   = 2
);
    logic [NREQ-1:0]       i_req;
    logic [NREQ*WIDTH-1:0] i_a_bus;
    logic [NREQ*WIDTH-1:0] i_b_bus;
    logic [NREQ-1:0]       o_gnt;
    logic [WIDTH-1:0]      o_mult_a;
    logic [WIDTH-1:0]      o_mult_b;
    logic [WIDTH-1:0]      i_mult_o;
    logic                  o_valid;
    logic [IDW-1:0]        o_id;
    logic [WIDTH-1:0]      o_res;
    logic                  i_ready;

    modport slave (
        input  i_req, i_a_bus, i_b_bus, i_mult_o, i_ready,
        output o_gnt, o_mult_a, o_mult_b, o_valid, o_id, o_res
    );

    modport master (
        output i_req, i_a_bus, i_b_bus, i_mult_o, i_ready,
        input  o_gnt, o_mult_a, o_mult_b, o_valid, o_id, o_res
    );
endinterface

// File: rtl/mult_share_arb.sv
// mult_share_arb: round-robin sharing of one multiplier among NREQ requesters with a one-deep result stage
module mult_share_arb #(
    parameter int WIDTH = 24,
    parameter int FRAC  = 16,
    parameter int NREQ  = 4,
    parameter int IDW   = 2
) (
    input logic             clk,
    input logic             rst_n,
    mult_share_arb_if.slave bus
);
    typedef enum logic {S_EMPTY, S_FULL} state_t;

    state_t           r_state;
    logic [IDW-1:0]   r_ptr;
    logic [IDW-1:0]   r_id;
    logic [WIDTH-1:0] r_res;
    logic [IDW-1:0]   w_win;
    logic             w_issue;
    logic [WIDTH-1:0] w_a [NREQ];
    logic [WIDTH-1:0] w_b [NREQ];

    if (IDW != $clog2(NREQ) || FRAC >= WIDTH || NREQ < 2 || NREQ > 16) begin : g_param_err
        $error("mult_share_arb: inconsistent parameters");
    end

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign w_a[g] = bus.i_a_bus[g*WIDTH +: WIDTH];
        assign w_b[g] = bus.i_b_bus[g*WIDTH +: WIDTH];
    end

    // first requester at or above the pointer, wrapping; lowest offset written last wins
    always_comb begin
        logic [IDW-1:0] j;
        w_win = r_ptr;
        for (int k = NREQ - 1; k >= 0; k--) begin
            j = IDW'((int'(r_ptr) + k) % NREQ);
            if (bus.i_req[j]) w_win = j;
        end
    end

    // a new product can be taken whenever the result slot is empty or being drained
    assign w_issue      = (|bus.i_req) && (r_state == S_EMPTY || bus.i_ready);
    assign bus.o_gnt    = w_issue ? NREQ'(1) << w_win : '0;
    assign bus.o_mult_a = w_issue ? w_a[w_win] : '0;
    assign bus.o_mult_b = w_issue ? w_b[w_win] : '0;
    assign bus.o_valid  = (r_state == S_FULL);
    assign bus.o_id     = r_id;
    assign bus.o_res    = r_res;

    // result stage: capture the multiplier output on issue, drain on accept, otherwise hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_EMPTY;
            r_res   <= '0;
            r_id    <= '0;
            r_ptr   <= '0;
        end else if (w_issue) begin
            r_state <= S_FULL;
            r_res   <= bus.i_mult_o;
            r_id    <= w_win;
            r_ptr   <= (w_win == IDW'(NREQ - 1)) ? '0 : w_win + 1'b1;
        end else if (r_state == S_FULL && bus.i_ready) begin
            r_state <= S_EMPTY;
        end
    end
endmodule

// File: tb/tb_mult_share_arb.sv
// tb_mult_share_arb: directed scoreboard bench for the shared-multiplier arbiter
module tb_mult_share_arb;
    localparam int W = 24;
    localparam int F = 16;
    localparam int N = 4;
    localparam int I = 2;

    typedef struct packed {
        logic [I-1:0] id;
        logic [W-1:0] res;
    } ent_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;
    int   m_ptr = 0;
    ent_t q[$];

    always #5 clk = ~clk;

    mult_share_arb_if #(.WIDTH(W), .NREQ(N), .IDW(I)) bus ();

    mult_share_arb #(.WIDTH(W), .FRAC(F), .NREQ(N), .IDW(I)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // fixed-point multiplier: product bits [F+W-1:F] plus round bit F-1, wrapping
    function automatic logic [W-1:0] fmul(logic [W-1:0] a, logic [W-1:0] b);
        logic signed [2*W-1:0] p;
        p = $signed(a) * $signed(b);
        return p[F+W-1:F] + {{(W-1){1'b0}}, p[F-1]};
    endfunction

    assign bus.i_mult_o = fmul(bus.o_mult_a, bus.o_mult_b);

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_op(int k, logic [W-1:0] a, logic [W-1:0] b);
        bus.i_a_bus[k*W +: W] = a;
        bus.i_b_bus[k*W +: W] = b;
    endtask

    // one clock: compare against the model at the falling edge, advance the model at the rising edge
    task automatic cyc();
        logic         e_issue;
        logic [I-1:0] e_win;
        logic [I-1:0] j;
        logic [W-1:0] ea;
        logic [W-1:0] eb;
        @(negedge clk);
        e_issue = (|bus.i_req) && (q.size() == 0 || bus.i_ready);
        e_win = I'(m_ptr);
        for (int k = N - 1; k >= 0; k--) begin
            j = I'((m_ptr + k) % N);
            if (bus.i_req[j]) e_win = j;
        end
        ea = e_issue ? bus.i_a_bus[int'(e_win)*W +: W] : '0;
        eb = e_issue ? bus.i_b_bus[int'(e_win)*W +: W] : '0;
        chk("gnt", 64'(bus.o_gnt), e_issue ? 64'(4'b0001 << e_win) : 64'd0);
        chk("mult_a", 64'(bus.o_mult_a), 64'(ea));
        chk("mult_b", 64'(bus.o_mult_b), 64'(eb));
        chk("valid", 64'(bus.o_valid), 64'(q.size() != 0));
        if (q.size() != 0) begin
            chk("id", 64'(bus.o_id), 64'(q[0].id));
            chk("res", 64'(bus.o_res), 64'(q[0].res));
        end
        @(posedge clk);
        if (q.size() != 0 && bus.i_ready) void'(q.pop_front());
        if (e_issue) begin
            q.push_back({e_win, fmul(ea, eb)});
            m_ptr = (int'(e_win) + 1) % N;
        end
        #1;
    endtask

    initial begin
        bus.i_req   = '0;
        bus.i_a_bus = '0;
        bus.i_b_bus = '0;
        bus.i_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", 64'(bus.o_valid), 64'd0);
        chk("rst_res", 64'(bus.o_res), 64'd0);
        chk("rst_id", 64'(bus.o_id), 64'd0);
        chk("rst_gnt", 64'(bus.o_gnt), 64'd0);
        chk("rst_mult_a", 64'(bus.o_mult_a), 64'd0);
        chk("rst_mult_b", 64'(bus.o_mult_b), 64'd0);
        rst_n = 1'b1;
        cyc();
        chk("idle_valid", 64'(bus.o_valid), 64'd0);

        bus.i_ready = 1'b1;
        set_op(0, 24'h018000, 24'h020000);
        bus.i_req = 4'b0001;
        cyc();
        chk("p1_res", 64'(bus.o_res), 64'h030000);
        chk("p1_id", 64'(bus.o_id), 64'd0);
        set_op(0, 24'hFF0000, 24'h008000);
        cyc();
        chk("p2_res", 64'(bus.o_res), 64'hFF8000);
        set_op(0, 24'h000001, 24'h008000);
        cyc();
        chk("p3_res", 64'(bus.o_res), 64'h000001);
        bus.i_req = '0;
        cyc();
        cyc();

        set_op(3, 24'h000100, 24'h000200);
        bus.i_req = 4'b1000;
        cyc();
        for (int k = 0; k < N; k++) set_op(k, W'($urandom), W'($urandom));
        bus.i_req = 4'b1111;
        for (int i = 0; i < 6; i++) begin
            cyc();
            chk("rr_id", 64'(bus.o_id), 64'(i % N));
            chk("rr_valid", 64'(bus.o_valid), 64'd1);
        end

        bus.i_req = 4'b1001;
        cyc();
        chk("wrap_id3a", 64'(bus.o_id), 64'd3);
        cyc();
        chk("wrap_id0", 64'(bus.o_id), 64'd0);
        cyc();
        chk("wrap_id3b", 64'(bus.o_id), 64'd3);

        set_op(1, 24'h018000, 24'h020000);
        bus.i_req = 4'b0010;
        cyc();
        chk("bp_setup_id", 64'(bus.o_id), 64'd1);
        chk("bp_setup_res", 64'(bus.o_res), 64'h030000);
        bus.i_ready = 1'b0;
        bus.i_req = 4'b1111;
        repeat (5) begin
            cyc();
            chk("bp_id", 64'(bus.o_id), 64'd1);
            chk("bp_res", 64'(bus.o_res), 64'h030000);
        end
        bus.i_ready = 1'b1;
        cyc();
        chk("bp_release_id", 64'(bus.o_id), 64'd2);

        cyc();
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(bus.o_valid), 64'd0);
        chk("mid_rst_res", 64'(bus.o_res), 64'd0);
        chk("mid_rst_id", 64'(bus.o_id), 64'd0);
        q.delete();
        m_ptr = 0;
        rst_n = 1'b1;
        cyc();
        chk("post_rst_id", 64'(bus.o_id), 64'd0);
        chk("post_rst_valid", 64'(bus.o_valid), 64'd1);
        bus.i_req = '0;
        cyc();
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
